// File: rtl/cdp_wdma_pkg.sv
// Shared widths, packet field offsets and packet builders for the CDP WDMA request packer.
// A request packet is either a write command or a 512-bit data beat, selected by the tag bit.
package cdp_wdma_pkg;

  localparam int AW  = 64;
  localparam int SZW = 13;
  localparam int DW  = 512;
  localparam int PDW = DW + 2 + 1;

  localparam int PKT_TAG_BIT  = 514;
  localparam int CMD_SIZE_LSB = 64;
  localparam int CMD_ACK_BIT  = 77;
  localparam int MASK_LSB     = 512;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_e;

  function automatic logic [PDW-1:0] mk_cmd_pd(input logic [AW-1:0]  addr,
                                               input logic [SZW-1:0] size,
                                               input logic           ack);
    logic [PDW-1:0] pd;
    pd                          = '0;
    pd[AW-1:0]                  = addr;
    pd[CMD_SIZE_LSB +: SZW]     = size;
    pd[CMD_ACK_BIT]             = ack;
    pd[PKT_TAG_BIT]             = 1'b0;
    return pd;
  endfunction

  function automatic logic [PDW-1:0] mk_dat_pd(input logic [DW-1:0] data,
                                               input logic [1:0]    mask);
    logic [PDW-1:0] pd;
    pd                  = '0;
    pd[DW-1:0]          = data;
    pd[MASK_LSB +: 2]   = mask;
    pd[PKT_TAG_BIT]     = 1'b1;
    return pd;
  endfunction

endpackage

// File: rtl/cdp_wdma_req_packer.sv
// Merges a write-command channel and a data-beat channel into one registered DMA
// write-request stream: one command packet, then ceil(atoms/2) data packets.
module cdp_wdma_req_packer
  import cdp_wdma_pkg::*;
(
  input  logic           nvdla_core_clk,
  input  logic           nvdla_core_rst,
  input  logic           cmd_vld,
  output logic           cmd_rdy,
  input  logic [AW-1:0]  cmd_addr,
  input  logic [SZW-1:0] cmd_size,
  input  logic           cmd_require_ack,
  input  logic           dat_vld,
  output logic           dat_rdy,
  input  logic [DW-1:0]  dat_data,
  output logic           dma_wr_req_vld,
  input  logic           dma_wr_req_rdy,
  output logic [PDW-1:0] dma_wr_req_pd,
  output logic           pkt_busy
);

  state_e         state_q;
  logic           vld_q;
  logic [PDW-1:0] pd_q;
  logic [SZW-1:0] beats_q, beats_d;
  logic [1:0]     last_mask_q, last_mask_d;
  logic [1:0]     beat_mask;
  logic           ld;
  logic           cmd_acc;
  logic           dat_acc;
  logic           last_beat;

  // The output slot may be (re)loaded whenever it is empty or being drained this cycle.
  assign ld        = !vld_q | dma_wr_req_rdy;
  assign cmd_rdy   = (state_q == IDLE) & ld;
  assign dat_rdy   = (state_q == DATA) & ld;
  assign cmd_acc   = cmd_vld & cmd_rdy;
  assign dat_acc   = dat_vld & dat_rdy;
  assign last_beat = (beats_q == SZW'(1));
  assign beat_mask = last_beat ? last_mask_q : 2'b11;

  always_comb begin
    beats_d     = beats_q;
    last_mask_d = last_mask_q;
    if (cmd_acc) begin
      beats_d     = (cmd_size >> 1) + SZW'(1);
      last_mask_d = cmd_size[0] ? 2'b11 : 2'b01;
    end else if (dat_acc) begin
      beats_d     = beats_q - SZW'(1);
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q     <= IDLE;
      vld_q       <= 1'b0;
      pd_q        <= '0;
      beats_q     <= '0;
      last_mask_q <= 2'b01;
    end else begin
      beats_q     <= beats_d;
      last_mask_q <= last_mask_d;
      case (state_q)
        IDLE: begin
          if (cmd_acc) begin
            pd_q    <= mk_cmd_pd(cmd_addr, cmd_size, cmd_require_ack);
            vld_q   <= 1'b1;
            state_q <= DATA;
          end else if (ld) begin
            vld_q   <= 1'b0;
          end
        end
        DATA: begin
          if (dat_acc) begin
            pd_q  <= mk_dat_pd(dat_data, beat_mask);
            vld_q <= 1'b1;
            if (last_beat) state_q <= IDLE;
          end else if (ld) begin
            vld_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dma_wr_req_vld = vld_q;
  assign dma_wr_req_pd  = pd_q;
  assign pkt_busy       = (state_q == DATA) | (vld_q & ~pd_q[PKT_TAG_BIT]);

`ifndef SYNTHESIS
  // Misaligned addresses are passed through untouched; flag them in simulation only.
  a_cmd_addr_aligned: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    (cmd_vld && cmd_rdy) |-> (cmd_addr[4:0] == 5'd0));
`endif

endmodule

// File: tb/tb_cdp_wdma_req_packer.sv
// Self-checking bench: per-command vector table, hand-built stall/ordering/reset
// sequences, and randomized streams compared against an expected-packet queue.
module tb_cdp_wdma_req_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_vld;
  logic         cmd_rdy;
  logic [63:0]  cmd_addr;
  logic [12:0]  cmd_size;
  logic         cmd_require_ack;
  logic         dat_vld;
  logic         dat_rdy;
  logic [511:0] dat_data;
  logic         dma_wr_req_vld;
  logic         dma_wr_req_rdy;
  logic [514:0] dma_wr_req_pd;
  logic         pkt_busy;

  always #5 clk = ~clk;

  cdp_wdma_req_packer dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rst  (rst),
    .cmd_vld         (cmd_vld),
    .cmd_rdy         (cmd_rdy),
    .cmd_addr        (cmd_addr),
    .cmd_size        (cmd_size),
    .cmd_require_ack (cmd_require_ack),
    .dat_vld         (dat_vld),
    .dat_rdy         (dat_rdy),
    .dat_data        (dat_data),
    .dma_wr_req_vld  (dma_wr_req_vld),
    .dma_wr_req_rdy  (dma_wr_req_rdy),
    .dma_wr_req_pd   (dma_wr_req_pd),
    .pkt_busy        (pkt_busy)
  );

  typedef struct {
    logic [63:0] addr;
    logic [12:0] size;
    logic        ack;
  } cmd_t;

  typedef struct {
    logic [63:0] addr;
    logic [12:0] size;
    logic        ack;
    int          beats;
    logic [1:0]  last_mask;
  } vec_t;

  cmd_t         cmd_q[$];
  logic [511:0] dat_q[$];
  logic [514:0] exp_q[$];
  int           checks   = 0;
  int           failures = 0;
  int           out_cnt;
  logic [514:0] last_out;

  task automatic chk(input string name, input logic [514:0] act, input logic [514:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [511:0] rand_beat();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_model();
    cmd_q.delete();
    dat_q.delete();
    exp_q.delete();
  endtask

  // Expected stream: the command packet, then every ceil((size+1)/2) beats in arrival order;
  // only the final beat of an even size (odd atom count) carries a half mask.
  task automatic add_cmd(input logic [63:0] addr, input logic [12:0] size, input logic ack);
    cmd_t         c;
    int           nb;
    logic [511:0] d;
    logic [1:0]   m;
    c.addr = addr;
    c.size = size;
    c.ack  = ack;
    cmd_q.push_back(c);
    exp_q.push_back({1'b0, 436'd0, ack, size, addr});
    nb = (int'(size) + 2) / 2;
    for (int b = 0; b < nb; b++) begin
      d = rand_beat();
      m = (b == nb - 1 && size[0] == 1'b0) ? 2'b01 : 2'b11;
      dat_q.push_back(d);
      exp_q.push_back({1'b1, m, d});
    end
  endtask

  task automatic run(input int budget, input int p_cmd, input int p_dat, input int p_rdy,
                     input int stall_at, input int cmd_delay, input int stop_after);
    int           ci = 0;
    int           di = 0;
    int           cyc = 0;
    int           target;
    bit           prev_stall = 1'b0;
    logic [514:0] prev_pd = '0;
    target  = (stop_after < 0) ? exp_q.size() : stop_after;
    out_cnt = 0;
    while (out_cnt < target && cyc < budget) begin
      @(negedge clk);
      cmd_vld = (ci < cmd_q.size()) && (cyc >= cmd_delay) && ($urandom_range(99) < p_cmd);
      if (ci < cmd_q.size()) begin
        cmd_addr        = cmd_q[ci].addr;
        cmd_size        = cmd_q[ci].size;
        cmd_require_ack = cmd_q[ci].ack;
      end
      dat_vld = (di < dat_q.size()) && ($urandom_range(99) < p_dat);
      if (di < dat_q.size()) dat_data = dat_q[di];
      if (cyc >= stall_at && cyc < stall_at + 5) dma_wr_req_rdy = 1'b0;
      else dma_wr_req_rdy = ($urandom_range(99) < p_rdy);
      #1;
      if (prev_stall) begin
        chk("hold_vld", dma_wr_req_vld, 1);
        chk("hold_pd", dma_wr_req_pd, prev_pd);
      end
      if (dma_wr_req_vld && !dma_wr_req_rdy) chk("stall_dat_rdy", dat_rdy, 0);
      if (cyc < cmd_delay) chk("early_dat_rdy", dat_rdy, 0);
      if (dma_wr_req_vld && dma_wr_req_rdy) begin
        chk($sformatf("pkt%0d", out_cnt), dma_wr_req_pd, exp_q[out_cnt]);
        last_out = dma_wr_req_pd;
        out_cnt++;
      end
      prev_stall = dma_wr_req_vld && !dma_wr_req_rdy;
      prev_pd    = dma_wr_req_pd;
      if (cmd_vld && cmd_rdy) ci++;
      if (dat_vld && dat_rdy) di++;
      cyc++;
    end
    chk("pkt_count", out_cnt, target);
    if (stop_after < 0) begin
      @(negedge clk);
      cmd_vld        = 1'b0;
      dat_vld        = 1'b0;
      dma_wr_req_rdy = 1'b1;
      #1;
      chk("idle_busy", pkt_busy, 0);
      chk("idle_vld", dma_wr_req_vld, 0);
    end
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = {$urandom, $urandom};
    a[4:0] = 5'd0;
    return a;
  endfunction

  vec_t vecs[5];

  initial begin
    vecs[0] = '{64'h1000, 13'd3, 1'b1, 2, 2'b11};
    vecs[1] = '{64'h2000, 13'd0, 1'b0, 1, 2'b01};
    vecs[2] = '{64'h3020, 13'd4, 1'b1, 3, 2'b01};
    vecs[3] = '{64'h40e0, 13'd1, 1'b0, 1, 2'b11};
    vecs[4] = '{64'hffff_ffe0, 13'd5, 1'b1, 3, 2'b11};

    rst             = 1'b1;
    cmd_vld         = 1'b0;
    cmd_addr        = '0;
    cmd_size        = '0;
    cmd_require_ack = 1'b0;
    dat_vld         = 1'b0;
    dat_data        = '0;
    dma_wr_req_rdy  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_vld", dma_wr_req_vld, 0);
    chk("rst_pd", dma_wr_req_pd, 0);
    chk("rst_busy", pkt_busy, 0);
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_dat_rdy", dat_rdy, 0);

    for (int v = 0; v < 5; v++) begin
      clear_model();
      add_cmd(vecs[v].addr, vecs[v].size, vecs[v].ack);
      run(200, 100, 100, 100, 1 << 30, 0, -1);
      chk($sformatf("tbl%0d_beats", v), out_cnt - 1, vecs[v].beats);
      chk($sformatf("tbl%0d_mask", v), last_out[513:512], vecs[v].last_mask);
      $display("vector %0d size=%0d beats=%0d", v, vecs[v].size, out_cnt - 1);
    end

    clear_model();
    add_cmd(64'h5000, 13'd7, 1'b0);
    run(200, 100, 100, 100, 3, 0, -1);
    $display("stall sequence packets=%0d", out_cnt);

    clear_model();
    add_cmd(64'h6000, 13'd2, 1'b1);
    add_cmd(64'h7000, 13'd5, 1'b0);
    run(200, 100, 100, 100, 1 << 30, 6, -1);
    $display("data-before-cmd sequence packets=%0d", out_cnt);

    clear_model();
    add_cmd(64'h8000, 13'd15, 1'b1);
    run(200, 100, 100, 100, 1 << 30, 0, 3);
    @(negedge clk);
    rst     = 1'b1;
    cmd_vld = 1'b0;
    dat_vld = 1'b0;
    #1;
    chk("midrst_vld", dma_wr_req_vld, 0);
    chk("midrst_busy", pkt_busy, 0);
    chk("midrst_pd", dma_wr_req_pd, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    add_cmd(64'h9000, 13'd3, 1'b0);
    run(200, 100, 100, 100, 1 << 30, 0, -1);
    $display("reset-recovery sequence packets=%0d", out_cnt);

    clear_model();
    for (int k = 0; k < 12; k++)
      add_cmd(rand_addr(), 13'($urandom_range(40)), 1'($urandom_range(1)));
    run(5000, 60, 60, 60, 1 << 30, 0, -1);
    $display("random stream packets=%0d", out_cnt);

    clear_model();
    add_cmd(rand_addr(), 13'd8191, 1'b1);
    run(30000, 70, 80, 70, 1 << 30, 0, -1);
    chk("max_beats", out_cnt - 1, 4096);
    chk("max_mask", last_out[513:512], 2'b11);
    $display("max-size sequence packets=%0d", out_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
